// File: rtl/ps2_host_tx_if.sv
// Signal bundle between the PS/2 host transmitter and the logic around it.
// The slave modport is the transmitter's view; the master modport is the user's view.
interface ps2_host_tx_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic       start;
    logic [7:0] tx_data;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport slave (
        input  ps2_clock, ps2_data, start, tx_data,
        output ps2_clock_oe, ps2_data_oe, busy, rx_inhibit, done, ack_err, timeout_err
    );

    modport master (
        output ps2_clock, ps2_data, start, tx_data,
        input  ps2_clock_oe, ps2_data_oe, busy, rx_inhibit, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends one byte with odd
// parity on device-generated clocks, checks the device ACK and flags edge timeouts.
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ        = 100_000_000,
    parameter int INHIBIT_CYCLES     = 12_000,
    parameter int START_SETUP_CYCLES = 100,
    parameter int TIMEOUT_CYCLES     = 1_500_000,
    parameter int FILTER_LEN         = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    ps2_host_tx_if.slave  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_SETUP_CYCLES) ? INHIBIT_CYCLES : START_SETUP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int FLT_W     = $clog2(FILTER_LEN + 1);

    if (CLK_FREQ_HZ <= 0) begin : g_bad_clk
        $error("ps2_host_tx: CLK_FREQ_HZ must be positive");
    end

    // Line conditioning: index 0 is the PS/2 clock, index 1 the PS/2 data line.
    logic [1:0] pin_raw;
    logic [1:0] pin_filt;
    assign pin_raw = {bus.ps2_data, bus.ps2_clock};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cond
        logic             sync1_q;
        logic             sync2_q;
        logic             filt_q;
        logic [FLT_W-1:0] fcnt_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                filt_q  <= 1'b1;
                fcnt_q  <= '0;
            end else begin
                sync1_q <= pin_raw[gi];
                sync2_q <= sync1_q;
                if (sync2_q == filt_q) begin
                    fcnt_q <= '0;
                end else if (fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
                    filt_q <= sync2_q;
                    fcnt_q <= '0;
                end else begin
                    fcnt_q <= fcnt_q + 1'b1;
                end
            end
        end

        assign pin_filt[gi] = filt_q;
    end

    logic clk_filt;
    logic data_filt;
    logic clk_prev_q;
    logic fall;
    assign clk_filt  = pin_filt[0];
    assign data_filt = pin_filt[1];
    assign fall      = clk_prev_q & ~clk_filt;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [9:0]       frame_q, frame_d;
    logic             clock_oe_q, clock_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic             timed_out;

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        bit_idx_d     = bit_idx_q;
        frame_d       = frame_q;
        clock_oe_d    = clock_oe_q;
        data_oe_d     = data_oe_q;
        ack_err_d     = ack_err_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    frame_d       = {1'b1, ~^bus.tx_data, bus.tx_data};
                    ack_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    clock_oe_d    = 1'b1;
                    state_d       = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_W'(START_SETUP_CYCLES - 1)) begin
                    clock_oe_d = 1'b0;
                    bit_idx_d  = '0;
                    cnt_d      = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                // The stop bit is a 1 in the frame, so the tenth fall releases data.
                if (fall) begin
                    data_oe_d = ~frame_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + 1'b1;
                    cnt_d     = '0;
                    if (bit_idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (timed_out) begin
                    timeout_err_d = 1'b1;
                    clock_oe_d    = 1'b0;
                    data_oe_d     = 1'b0;
                    cnt_d         = '0;
                    state_d       = S_DONE;
                end
            end
            S_ACK: begin
                if (fall) begin
                    ack_err_d = data_filt;
                    cnt_d     = '0;
                    state_d   = S_WAIT_IDLE;
                end else if (timed_out) begin
                    timeout_err_d = 1'b1;
                    clock_oe_d    = 1'b0;
                    data_oe_d     = 1'b0;
                    cnt_d         = '0;
                    state_d       = S_DONE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_filt && data_filt) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (timed_out) begin
                    timeout_err_d = 1'b1;
                    clock_oe_d    = 1'b0;
                    data_oe_d     = 1'b0;
                    cnt_d         = '0;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d      = '0;
                clock_oe_d = 1'b0;
                data_oe_d  = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            frame_q       <= '0;
            clock_oe_q    <= 1'b0;
            data_oe_q     <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            clk_prev_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            frame_q       <= frame_d;
            clock_oe_q    <= clock_oe_d;
            data_oe_q     <= data_oe_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
            clk_prev_q    <= clk_filt;
        end
    end

    assign bus.ps2_clock_oe = clock_oe_q;
    assign bus.ps2_data_oe  = data_oe_q;
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.rx_inhibit   = bus.busy;
    assign bus.done         = (state_q == S_DONE);
    assign bus.ack_err      = ack_err_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard that clocks the
// frame out, reports the bits it sampled, and optionally ACKs; results compare to a frame model.
module tb_ps2_host_tx;
    localparam int INH   = 200;
    localparam int SETUP = 20;
    localparam int TO    = 3000;
    localparam int FILT  = 8;
    localparam int H     = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic dev_clk_rel  = 1'b1;
    logic dev_data_rel = 1'b1;
    assign bus.ps2_clock = ~bus.ps2_clock_oe & dev_clk_rel;
    assign bus.ps2_data  = ~bus.ps2_data_oe & dev_data_rel;

    ps2_host_tx #(
        .CLK_FREQ_HZ       (100_000_000),
        .INHIBIT_CYCLES    (INH),
        .START_SETUP_CYCLES(SETUP),
        .TIMEOUT_CYCLES    (TO),
        .FILTER_LEN        (FILT)
    ) dut (
        .clock  (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int t_coe_rise = 0, t_coe_fall = 0, t_doe_rise = 0, t_terr_rise = 0, t_done = 0;
    logic prev_coe = 1'b0, prev_doe = 1'b0, prev_terr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
        if (bus.ps2_clock_oe && !prev_coe) t_coe_rise <= cyc;
        if (!bus.ps2_clock_oe && prev_coe) t_coe_fall <= cyc;
        if (bus.ps2_data_oe && !prev_doe && bus.ps2_clock_oe) t_doe_rise <= cyc;
        if (bus.timeout_err && !prev_terr) t_terr_rise <= cyc;
        prev_coe  <= bus.ps2_clock_oe;
        prev_doe  <= bus.ps2_data_oe;
        prev_terr <= bus.timeout_err;
    end

    // Reference frame as the device should see it, bit 0 first: data, odd parity, stop.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic dev_run(input bit ack, input bit glitch, output logic [9:0] seen, output bit ok);
        int n;
        seen = '0;
        ok   = 1'b0;
        n    = 0;
        while (!(bus.ps2_clock_oe === 1'b0 && bus.ps2_data_oe === 1'b1) && n < INH + SETUP + 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= INH + SETUP + 200) return;
        ok = 1'b1;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            dev_clk_rel = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk_rel = 1'b1;
            seen[k] = bus.ps2_data;
            repeat (H / 2) @(negedge clk);
            if (glitch) begin
                dev_clk_rel = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk_rel = 1'b1;
            end
            repeat (H / 2) @(negedge clk);
        end
        if (ack) dev_data_rel = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk_rel = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk_rel = 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_data_rel = 1'b1;
        repeat (H / 2) @(negedge clk);
    endtask

    task automatic send_and_observe(input logic [7:0] b, input bit ack, input bit glitch, input bit extra,
                                    output logic [9:0] seen, output bit ok, output int dones);
        int d0;
        @(negedge clk);
        d0 = done_cnt;
        bus.tx_data = b;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.tx_data = 8'($urandom);
        fork
            dev_run(ack, glitch, seen, ok);
            begin
                if (extra) begin
                    repeat (INH + SETUP + 300) @(negedge clk);
                    bus.tx_data = 8'h00;
                    bus.start   = 1'b1;
                    @(negedge clk);
                    bus.start   = 1'b0;
                end
            end
        join
        repeat (40) @(negedge clk);
        dones = done_cnt - d0;
        $display("tx byte=%02h ack=%0d seen=%b dones=%0d ack_err=%0d timeout_err=%0d",
                 b, ack, seen, dones, bus.ack_err, bus.timeout_err);
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        bus.start = 1'b0;
        bus.tx_data = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy, bus.rx_inhibit, bus.done, bus.ack_err, bus.timeout_err};
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000", outs);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        outs = {bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy, bus.rx_inhibit, bus.done, bus.ack_err, bus.timeout_err};
        checks++;
        if (outs !== 7'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000000", outs);
        end
    endtask

    task automatic test_send_ed();
        logic [9:0] seen;
        bit ok;
        int dones;
        send_and_observe(8'hED, 1'b1, 1'b0, 1'b0, seen, ok, dones);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL ed_release: clock never released with start bit"); end
        checks++;
        if (t_doe_rise - t_coe_rise !== INH) begin
            errors++; $display("FAIL ed_inhibit_len: got %0d expected %0d", t_doe_rise - t_coe_rise, INH);
        end
        checks++;
        if (t_coe_fall - t_doe_rise !== SETUP) begin
            errors++; $display("FAIL ed_setup_len: got %0d expected %0d", t_coe_fall - t_doe_rise, SETUP);
        end
        checks++;
        if (seen !== exp_frame(8'hED)) begin
            errors++; $display("FAIL ed_frame: got %b expected %b", seen, exp_frame(8'hED));
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL ed_done_count: got %0d expected 1", dones); end
        checks++;
        if ({bus.ack_err, bus.timeout_err} !== 2'b00) begin
            errors++; $display("FAIL ed_errors: got %b expected 00", {bus.ack_err, bus.timeout_err});
        end
        checks++;
        if ({bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL ed_idle: got %b expected 000", {bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy});
        end
    endtask

    task automatic test_no_ack();
        logic [9:0] seen;
        bit ok;
        int dones;
        send_and_observe(8'hFF, 1'b0, 1'b0, 1'b0, seen, ok, dones);
        checks++;
        if (seen !== exp_frame(8'hFF)) begin
            errors++; $display("FAIL noack_frame: got %b expected %b", seen, exp_frame(8'hFF));
        end
        checks++;
        if (seen[8] !== 1'b1) begin errors++; $display("FAIL noack_parity: got %b expected 1", seen[8]); end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL noack_done_count: got %0d expected 1", dones); end
        checks++;
        if ({bus.ack_err, bus.timeout_err} !== 2'b10) begin
            errors++; $display("FAIL noack_errors: got %b expected 10", {bus.ack_err, bus.timeout_err});
        end
        checks++;
        if ({bus.ps2_clock_oe, bus.ps2_data_oe} !== 2'b00) begin
            errors++; $display("FAIL noack_released: got %b expected 00", {bus.ps2_clock_oe, bus.ps2_data_oe});
        end
    endtask

    task automatic test_random();
        logic [9:0] seen;
        logic [7:0] b;
        bit ok, ack;
        int dones;
        for (int i = 0; i < 5; i++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            send_and_observe(b, ack, 1'b0, 1'b0, seen, ok, dones);
            checks++;
            if (seen !== exp_frame(b)) begin
                errors++; $display("FAIL rand_frame[%0d]: got %b expected %b", i, seen, exp_frame(b));
            end
            checks++;
            if (dones !== 1) begin errors++; $display("FAIL rand_done_count[%0d]: got %0d expected 1", i, dones); end
            checks++;
            if ({bus.ack_err, bus.timeout_err} !== {~ack, 1'b0}) begin
                errors++; $display("FAIL rand_errors[%0d]: got %b expected %b", i, {bus.ack_err, bus.timeout_err}, {~ack, 1'b0});
            end
        end
    endtask

    task automatic test_timeout();
        int d0, n;
        @(negedge clk);
        d0 = done_cnt;
        bus.tx_data = 8'($urandom);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < INH + SETUP + TO + 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        $display("tx timeout case: terr=%0d after %0d cycles", bus.timeout_err, n);
        checks++;
        if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", bus.timeout_err); end
        checks++;
        if (t_terr_rise - t_coe_fall !== TO) begin
            errors++; $display("FAIL timeout_delay: got %0d expected %0d", t_terr_rise - t_coe_fall, TO);
        end
        checks++;
        if (done_cnt - d0 !== 1 || t_done !== t_terr_rise) begin
            errors++; $display("FAIL timeout_done: got count %0d at %0d expected 1 at %0d", done_cnt - d0, t_done, t_terr_rise);
        end
        checks++;
        if ({bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy, bus.ack_err} !== 4'b0000) begin
            errors++; $display("FAIL timeout_released: got %b expected 0000",
                               {bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy, bus.ack_err});
        end
    endtask

    task automatic test_ignored_start();
        logic [9:0] seen;
        logic [7:0] b;
        bit ok;
        int dones;
        b = 8'($urandom_range(1, 255));
        send_and_observe(b, 1'b1, 1'b0, 1'b1, seen, ok, dones);
        checks++;
        if (seen !== exp_frame(b)) begin
            errors++; $display("FAIL busy_start_frame: got %b expected %b", seen, exp_frame(b));
        end
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", dones); end
        repeat (INH + 50) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued: got busy %b expected 0", bus.busy); end
    endtask

    task automatic test_glitch();
        logic [9:0] seen;
        logic [7:0] b;
        bit ok;
        int dones;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_and_observe(b, 1'b1, 1'b1, 1'b0, seen, ok, dones);
            checks++;
            if (seen !== exp_frame(b)) begin
                errors++; $display("FAIL glitch_frame[%0d]: got %b expected %b", i, seen, exp_frame(b));
            end
            checks++;
            if (dones !== 1 || bus.ack_err !== 1'b0 || bus.timeout_err !== 1'b0) begin
                errors++; $display("FAIL glitch_status[%0d]: got dones %0d ack_err %b terr %b expected 1 0 0",
                                   i, dones, bus.ack_err, bus.timeout_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] seen;
        logic [3:0] outs;
        bit ok;
        int dones, n;
        @(negedge clk);
        bus.tx_data = 8'hED;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.ps2_clock_oe === 1'b0 && bus.ps2_data_oe === 1'b1) && n < INH + SETUP + 200) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dev_clk_rel = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk_rel = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_clk_rel = 1'b0;
        repeat (H / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        outs = {bus.ps2_clock_oe, bus.ps2_data_oe, bus.busy, bus.rx_inhibit};
        $display("tx reset mid-byte: outputs during reset %b", outs);
        checks++;
        if (outs !== 4'b0000) begin errors++; $display("FAIL midreset_outputs: got %b expected 0000", outs); end
        repeat (3) @(negedge clk);
        dev_clk_rel  = 1'b1;
        dev_data_rel = 1'b1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        send_and_observe(8'hED, 1'b1, 1'b0, 1'b0, seen, ok, dones);
        checks++;
        if (seen !== exp_frame(8'hED)) begin
            errors++; $display("FAIL midreset_resend_frame: got %b expected %b", seen, exp_frame(8'hED));
        end
        checks++;
        if (dones !== 1 || {bus.ack_err, bus.timeout_err} !== 2'b00) begin
            errors++; $display("FAIL midreset_resend_status: got dones %0d errs %b expected 1 00",
                               dones, {bus.ack_err, bus.timeout_err});
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_no_ack();
        test_random();
        test_timeout();
        test_ignored_start();
        test_glitch();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
